// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: shadow inputs from the stopwatch
// counters and the scanned seg/an outputs toward the board pins.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output digits_in, dp_in, blank_in, blink_en, load,
        input  seg, dp, an, digit_idx
    );

    modport slave (
        input  digits_in, dp_in, blank_in, blink_en, load,
        output seg, dp, an, digit_idx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadowed display value,
// per-digit dp/blank/blink and an all-off dead time at the start of each slot.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 1000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input logic              clk,
    input logic              resett,
    seg_scan_driver_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   blink_en_q, blink_en_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0] cur_digit;
    logic       cur_dp;
    logic       cur_blank;
    logic       cur_blink;
    logic       dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        digits_d      = digits_q;
        dp_sh_d       = dp_sh_q;
        blank_d       = blank_q;
        blink_en_d    = blink_en_q;
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        blk_cnt_d     = blk_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;

        if (bus.load) begin
            digits_d   = bus.digits_in;
            dp_sh_d    = bus.dp_in;
            blank_d    = bus.blank_in;
            blink_en_d = bus.blink_en;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d     = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Outputs are computed from this cycle's registered state and land one edge later.
    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = digits_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_blank = blank_q[i];
                cur_blink = blink_en_q[i];
            end
        end

        dark = (cnt_q < DEAD_END) || cur_blank || (cur_blink && blink_phase_q);

        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (!dark) begin
            seg_d = hex_to_seg(cur_digit);
            dp_d  = ~cur_dp;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) an_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            digits_q      <= '0;
            dp_sh_q       <= '0;
            blank_q       <= '0;
            blink_en_q    <= '0;
            seg_q         <= '1;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            digits_q      <= digits_d;
            dp_sh_q       <= dp_sh_d;
            blank_q       <= blank_d;
            blink_en_q    <= blink_en_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx_q;
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised time-multiplexed seven-segment scan driver for the stopwatch display path. It replaces the fixed single-digit drive with a scan over NUM_DIGITS digits, adding per-digit decimal point, blanking, blink, anti-ghosting dead time and tear-free capture of the displayed value. It sits between the stopwatch counters and the board's seg/an pins, and decodes hex 0-F internally.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least 2.
- DEAD_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be at least 1.
- clk  in  1  system clock; single clock domain.
- resett  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- blank_in  in  NUM_DIGITS  force digit dark, active-high.
- blink_en  in  NUM_DIGITS  digit goes dark during the blink-off phase.
- load  in  1  one-cycle strobe that captures all *_in and blink_en into shadow registers.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot or all-off.
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of the current slot's digit.

## Operation
- Shadow registers hold digits, dp, blank and blink_en. They update only on a clk edge with load=1, and are the only source for display, so a multi-digit value never tears.
- Slot counter cnt runs 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and digit_idx advances. digit_idx wraps from NUM_DIGITS-1 to 0. When NUM_DIGITS=1, digit_idx stays at 0.
- Blink counter runs 0..BLINK_DIV-1. At the terminal count it wraps and blink_phase toggles. blink_phase=1 is the off phase. It free-runs regardless of load.
- Dark condition for the current digit d: cnt < DEAD_CYCLES, or blank[d], or (blink_en[d] and blink_phase).
- When dark: an = all 1s, seg = 7'b1111111, dp = 1.
- When lit: an = all 1s except bit d = 0; seg = hex decode of digit d; dp = ~dp_shadow[d].
- Hex decode, as seg {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset, applied synchronously:
  - cnt=0, digit_idx=0, blink counter=0, blink_phase=0, all shadows=0.
  - Next-cycle outputs: an=all 1s, seg=1111111, dp=1.
- Reset mid-slot aborts the slot immediately; the scan restarts at digit 0 with a full dead time. Reset has priority over load.

## Timing
- seg, dp and an are registered. They reflect the cnt, digit_idx, blink_phase and shadow values of the previous cycle, giving 1 cycle of latency.
- load at edge k: the new value is visible on the outputs after edge k+1, provided the digit is lit then.
- Each digit is dark for DEAD_CYCLES cycles, then lit for REFRESH_DIV-DEAD_CYCLES cycles. The full frame is NUM_DIGITS*REFRESH_DIV cycles.
- an never has more than one bit low. Anodes never switch directly from one digit to another without at least DEAD_CYCLES all-off cycles between them, which is the anti-ghosting guarantee.
- Simultaneous events:
  - load on the slot-wrap edge: the new shadow is used from the new slot's first lit cycle.
  - blink toggle mid-slot: takes effect on the next registered output, without waiting for a slot boundary.
- digit_idx is registered and changes on the same edge at which cnt wraps to 0.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_DIV=64.
- Reset: hold resett 3 cycles, then release.
  - During reset and the first cycle after: an=1111, seg=1111111, dp=1.
  - Slot 0: dark for the first 2 cycles, then an=1110 for 6 cycles.
  - digit_idx then reads 1.
- Scan and decode: load digits_in=16'h12AF, dp_in=4'b0100, blank/blink=0.
  - Frame sequence: an 1110/seg 0001110, an 1101/seg 0001000, an 1011/seg 0100100 with dp=0, an 0111/seg 1111001.
  - Every lit slot is separated from the next by 2 all-off cycles. an is never more than one-hot.
- Tear-free: change digits_in to 16'h3456 without asserting load.
  - Display unchanged over 2 frames.
  - Pulse load: the next lit slot shows the new digit.
- Blank and blink: load blank_in=4'b0010, blink_en=4'b0001.
  - Digit 1 is never lit.
  - Digit 0 is lit while blink_phase=0 and dark for 64 cycles while blink_phase=1, alternating.
- Wrap and reset mid-slot: assert resett while digit_idx=3 and cnt=5.
  - Next-cycle an=1111, digit_idx=0, shadows cleared.
  - After release, digit 0 shows seg 1000000, i.e. "0".
- NUM_DIGITS=1 instance: an toggles between 1 (dark, 2 cycles) and 0 (lit, 6 cycles); digit_idx is constantly 0.
